// File: rtl/flash_prefetch_buffer.sv
// flash_prefetch_buffer
//
// Single-line read prefetch buffer that sits between a CPU Avalon read master
// and the FlashBusInterface MEM read port. A miss fetches the whole aligned
// line from flash one word at a time, always starting at word 0. Words that
// have already arrived are returned with zero wait states.
//
// Ports:
//   i_Clk                 system clock, rising edge
//   i_Reset               asynchronous active-high reset
//   i_AV_CPU_Addr         CPU word address
//   i_AV_CPU_Read         CPU read request, held until WaitRequest is low
//   o_AV_CPU_ReadData     read data, valid when Read is high and WaitRequest is low
//   o_AV_CPU_WaitRequest  stall to the CPU; low only on a hit
//   o_AV_MEM_Addr         word address to the MEM port
//   o_AV_MEM_Read         read request to the MEM port
//   i_AV_MEM_ReadData     MEM read data
//   i_AV_MEM_WaitRequest  MEM port stall
//   i_Invalidate          single-cycle pulse that discards the buffered line
//   o_Busy                high while a line fill is in progress

module flash_prefetch_buffer #(
    parameter int unsigned ADDR_BITS       = 30,
    parameter int unsigned LINE_WORDS_LOG2 = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic [ADDR_BITS-1:0] i_AV_CPU_Addr,
    input  logic                 i_AV_CPU_Read,
    output logic [31:0]          o_AV_CPU_ReadData,
    output logic                 o_AV_CPU_WaitRequest,
    output logic [ADDR_BITS-1:0] o_AV_MEM_Addr,
    output logic                 o_AV_MEM_Read,
    input  logic [31:0]          i_AV_MEM_ReadData,
    input  logic                 i_AV_MEM_WaitRequest,
    input  logic                 i_Invalidate,
    output logic                 o_Busy
);

    localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_LOG2;
    localparam int unsigned TAG_BITS   = ADDR_BITS - LINE_WORDS_LOG2;

    typedef enum logic {
        StIdle,
        StFill
    } state_t;

    state_t                     state;
    logic [TAG_BITS-1:0]        tag;
    logic [31:0]                line_data [LINE_WORDS];
    logic [LINE_WORDS-1:0]      valid;
    logic                       stale;
    logic [LINE_WORDS_LOG2-1:0] count;
    logic [31:0]                last_data;

    logic [TAG_BITS-1:0]        cpu_tag;
    logic [LINE_WORDS_LOG2-1:0] cpu_word;
    logic                       hit;

    assign cpu_tag  = i_AV_CPU_Addr[ADDR_BITS-1:LINE_WORDS_LOG2];
    assign cpu_word = i_AV_CPU_Addr[LINE_WORDS_LOG2-1:0];

    // A hit is served in any state, including mid-fill for words already stored.
    assign hit = i_AV_CPU_Read && (cpu_tag == tag) && valid[cpu_word];

    assign o_AV_CPU_WaitRequest = !hit;
    // Outside a hit the last delivered word is held.
    assign o_AV_CPU_ReadData    = hit ? line_data[cpu_word] : last_data;
    assign o_AV_MEM_Read        = (state == StFill);
    assign o_AV_MEM_Addr        = {tag, count};
    assign o_Busy               = (state == StFill);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= StIdle;
            tag       <= '0;
            valid     <= '0;
            stale     <= 1'b0;
            count     <= '0;
            last_data <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_data[i] <= '0;
            end
        end else begin
            if (hit) begin
                last_data <= line_data[cpu_word];
            end

            case (state)
                StIdle: begin
                    // A miss takes priority over a coincident invalidate.
                    if (i_AV_CPU_Read && !hit) begin
                        state <= StFill;
                        tag   <= cpu_tag;
                        valid <= '0;
                        stale <= 1'b0;
                        count <= '0;
                    end else if (i_Invalidate) begin
                        valid <= '0;
                    end
                end

                StFill: begin
                    // A fill is never aborted; stale keeps late words from validating.
                    if (i_Invalidate) begin
                        valid <= '0;
                        stale <= 1'b1;
                    end
                    if (!i_AV_MEM_WaitRequest) begin
                        line_data[count] <= i_AV_MEM_ReadData;
                        if (!stale && !i_Invalidate) begin
                            valid[count] <= 1'b1;
                        end
                        count <= count + 1'b1;
                        if (&count) begin
                            state <= StIdle;
                        end
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_prefetch_buffer.sv
// Directed bench for flash_prefetch_buffer with a flash MEM-port responder
// (data = addr ^ 0xA5A50000, programmable per-word latency) and queues of
// expected MEM addresses and CPU read data.

module tb_flash_prefetch_buffer;

    logic        clk;
    logic        rst;
    logic [29:0] cpu_addr;
    logic        cpu_read;
    logic [31:0] cpu_rdata;
    logic        cpu_wait;
    logic [29:0] mem_addr;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_wait;
    logic        inval;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          mem_lat      = 0;
    int          wait_left    = 0;
    bit          new_req      = 1'b1;
    logic [29:0] cur_addr     = '0;
    int          mem_reads    = 0;
    int          pushed_total = 0;

    logic [29:0] exp_mem_q [$];
    logic [31:0] exp_cpu_q [$];

    flash_prefetch_buffer #(
        .ADDR_BITS      (30),
        .LINE_WORDS_LOG2(2)
    ) dut (
        .i_Clk               (clk),
        .i_Reset             (rst),
        .i_AV_CPU_Addr       (cpu_addr),
        .i_AV_CPU_Read       (cpu_read),
        .o_AV_CPU_ReadData   (cpu_rdata),
        .o_AV_CPU_WaitRequest(cpu_wait),
        .o_AV_MEM_Addr       (mem_addr),
        .o_AV_MEM_Read       (mem_read),
        .i_AV_MEM_ReadData   (mem_rdata),
        .i_AV_MEM_WaitRequest(mem_wait),
        .i_Invalidate        (inval),
        .o_Busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] flash_data(input logic [29:0] a);
        return {2'b00, a} ^ 32'hA5A50000;
    endfunction

    task automatic push_line(input logic [29:0] base);
        for (int i = 0; i < 4; i++) begin
            exp_mem_q.push_back(base + 30'(i));
        end
        pushed_total += 4;
    endtask

    // Flash responder: decides WaitRequest for the coming edge at each negedge.
    initial begin
        mem_wait  = 1'b1;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!mem_read) begin
                mem_wait = 1'b1;
                new_req  = 1'b1;
            end else begin
                if (new_req) begin
                    new_req   = 1'b0;
                    cur_addr  = mem_addr;
                    wait_left = mem_lat;
                end else begin
                    chk("mem_addr_stable", {2'b00, mem_addr}, {2'b00, cur_addr});
                end
                if (wait_left > 0) begin
                    wait_left--;
                    mem_wait = 1'b1;
                end else begin
                    mem_wait  = 1'b0;
                    mem_rdata = flash_data(mem_addr);
                    new_req   = 1'b1;
                    mem_reads++;
                    checks++;
                    assert (exp_mem_q.size() != 0) else begin
                        errors++;
                        $error("FAIL mem_unexpected_read: observed addr %h expected none",
                               mem_addr);
                    end
                    if (exp_mem_q.size() != 0) begin
                        chk("mem_addr_order", {2'b00, mem_addr}, {2'b00, exp_mem_q.pop_front()});
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic cpu_read_chk(input logic [29:0] a, input int exp_waits);
        int   waits;
        bit   done;
        logic [31:0] exp;
        exp_cpu_q.push_back(flash_data(a));
        cpu_addr = a;
        cpu_read = 1'b1;
        waits    = 0;
        done     = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (!cpu_wait) begin
                exp = exp_cpu_q.pop_front();
                chk($sformatf("cpu_data@%h", a), cpu_rdata, exp);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(negedge clk);
        end
        cpu_read = 1'b0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL cpu_timeout@%h: observed no hit expected hit", a);
        end
        if (done) begin
            chk($sformatf("cpu_waits@%h", a), 32'(waits), 32'(exp_waits));
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 200 && !idle; c++) begin
            @(negedge clk);
            idle = !busy;
        end
        checks++;
        assert (idle) else begin
            errors++;
            $error("FAIL idle_timeout: observed busy expected idle");
        end
    endtask

    task automatic pulse_invalidate();
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({name, "_mem_addr"}, {2'b00, mem_addr}, 32'd0);
        chk({name, "_cpu_rdata"}, cpu_rdata, 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_cpu_wait"}, 32'(cpu_wait), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        cpu_addr = '0;
        cpu_read = 1'b0;
        inval    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss on 0x10, then zero-wait hits on the rest of the line.
        push_line(30'h10);
        cpu_read_chk(30'h10, 2);
        wait_idle();
        chk("fill_done_queue", 32'(exp_mem_q.size()), 32'd0);
        cpu_read_chk(30'h11, 0);
        cpu_read_chk(30'h12, 0);
        cpu_read_chk(30'h13, 0);
        chk("no_extra_mem_reads", 32'(mem_reads), 32'(pushed_total));

        // Invalidate in IDLE forces a refill.
        pulse_invalidate();
        push_line(30'h10);
        cpu_read_chk(30'h10, 2);
        wait_idle();

        // Miss on the last word still fills from word 0.
        pulse_invalidate();
        push_line(30'h10);
        cpu_read_chk(30'h13, 5);
        wait_idle();

        // Other-line read during a fill waits for the fill to finish.
        pulse_invalidate();
        push_line(30'h10);
        push_line(30'h24);
        cpu_read_chk(30'h10, 2);
        cpu_read_chk(30'h24, 4);
        wait_idle();
        chk("line24_queue", 32'(exp_mem_q.size()), 32'd0);

        // Invalidate mid-fill: the rest of the line is fetched but never hits.
        push_line(30'h10);
        push_line(30'h10);
        cpu_read_chk(30'h10, 2);
        pulse_invalidate();
        cpu_read_chk(30'h13, 6);
        wait_idle();
        cpu_read_chk(30'h12, 0);

        // Slow flash: 3 wait cycles per word.
        pulse_invalidate();
        mem_lat = 3;
        push_line(30'h10);
        cpu_read_chk(30'h12, 13);
        wait_idle();
        chk("slow_busy", 32'(busy), 32'd0);
        cpu_read_chk(30'h10, 0);
        cpu_read_chk(30'h11, 0);
        cpu_read_chk(30'h13, 0);
        chk("slow_mem_reads", 32'(mem_reads), 32'(pushed_total));

        // Reset in the middle of a fill.
        mem_lat  = 10;
        cpu_addr = 30'h24;
        cpu_read = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("prefill_busy", 32'(busy), 32'd1);
        chk("prefill_mem_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midfill_reset");
        @(negedge clk);
        cpu_read = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        mem_lat = 0;
        @(negedge clk);
        push_line(30'h10);
        cpu_read_chk(30'h10, 2);
        wait_idle();

        chk("final_mem_queue", 32'(exp_mem_q.size()), 32'd0);
        chk("final_cpu_queue", 32'(exp_cpu_q.size()), 32'd0);
        chk("final_mem_reads", 32'(mem_reads), 32'(pushed_total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
